// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// The winner's result is captured into a single registered response slot tagged with its id.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = 32,
    localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_ctl,
    input  logic [XLEN*NUM_REQ-1:0] req_in_1,
    input  logic [XLEN*NUM_REQ-1:0] req_in_2,
    output logic [3:0]              alu_ctl,
    output logic [XLEN-1:0]         alu_in_1,
    output logic [XLEN-1:0]         alu_in_2,
    input  logic [XLEN-1:0]         alu_out,
    input  logic [3:0]              alu_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [XLEN-1:0]         rsp_out,
    output logic [3:0]              rsp_flags
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_out_q, rsp_out_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;

    logic [3:0]      ctl_a [NUM_REQ];
    logic [XLEN-1:0] in1_a [NUM_REQ];
    logic [XLEN-1:0] in2_a [NUM_REQ];

    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    logic            any_valid;
    logic            can_accept;
    logic            accept;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ctl_a[i] = req_ctl[4*i +: 4];
            in1_a[i] = req_in_1[XLEN*i +: XLEN];
            in2_a[i] = req_in_2[XLEN*i +: XLEN];
        end
    end

    // Search starts one past the last grant so the previous winner has lowest priority.
    always_comb begin
        winner    = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign can_accept = (state_q == StEmpty) | rsp_ready;
    assign accept     = any_valid & can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        alu_ctl  = '0;
        alu_in_1 = '0;
        alu_in_2 = '0;
        if (any_valid) begin
            alu_ctl  = ctl_a[winner];
            alu_in_1 = in1_a[winner];
            alu_in_2 = in2_a[winner];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_flags_d  = rsp_flags_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // A same-cycle drain and accept reloads the slot and stays full.
                if (accept) begin
                    state_d = StFull;
                end else if (rsp_ready) begin
                    state_d = StEmpty;
                end
            end
        endcase
        if (accept) begin
            last_grant_d = winner;
            rsp_id_d     = winner;
            rsp_out_d    = alu_out;
            rsp_flags_d  = alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            last_grant_q <= IDW'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            rsp_out_q    <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;

endmodule
